// File: rtl/useq_mem_arb.sv
// useq_mem_arb: shares one BRAM port between the useq core and a host.
// The core normally has priority; a waiting host is force-granted after
// STARVE_MAX contended cycles. host_halt parks the core in reset and hands
// the port to the host exclusively, with a one-cycle release state on exit.
module useq_mem_arb #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_wren,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rst_n,
  input  logic              host_halt,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_CORE = 2'd0,
    ST_HALT = 2'd1,
    ST_HREL = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic        rvalid_q, rvalid_d;
  logic        core_rst_n_q, core_rst_n_d;

  logic        host_gnt_s;
  logic        core_own_s;
  logic        starve_at_lim_s;

  // Counter never exceeds the limit; >= keeps the compare robust anyway.
  assign starve_at_lim_s = (starve_q >= STARVE_LIM);

  // Arbitration, starvation counting and next-state selection.
  always_comb begin
    state_d    = state_q;
    starve_d   = 8'd0;
    host_gnt_s = 1'b0;
    core_own_s = 1'b0;
    if (rst) begin
      state_d = ST_CORE;
    end else begin
      case (state_q)
        ST_CORE: begin
          core_own_s = core_req;
          host_gnt_s = host_req & (~core_req | starve_at_lim_s);
          if (host_halt) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_CORE;
          end
          // Count only cycles where the host asked and the core won.
          if (host_req & ~host_gnt_s) begin
            starve_d = starve_at_lim_s ? starve_q : (starve_q + 8'd1);
          end else begin
            starve_d = 8'd0;
          end
        end
        ST_HALT: begin
          host_gnt_s = host_req;
          if (host_halt) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_HREL;
          end
        end
        ST_HREL: begin
          // Core is still in reset here, so the host keeps the port.
          host_gnt_s = host_req;
          if (host_halt) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_CORE;
          end
        end
        default: begin
          state_d = ST_CORE;
        end
      endcase
    end
  end

  // BRAM port steering: the granted host owns the port, else the core does.
  always_comb begin
    ram_addr = core_addr;
    ram_wren = 1'b0;
    ram_din  = core_wdata;
    if (host_gnt_s) begin
      ram_addr = host_addr;
      ram_wren = host_we;
      ram_din  = host_wdata;
    end else begin
      ram_addr = core_addr;
      ram_wren = core_own_s & core_wren;
      ram_din  = core_wdata;
    end
  end

  // Next values for the read-valid flag and the core reset line.
  always_comb begin
    rvalid_d     = host_gnt_s & ~host_we;
    core_rst_n_d = (state_d == ST_CORE) & ~rst;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CORE;
      starve_q     <= 8'd0;
      rvalid_q     <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rvalid_q     <= rvalid_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign host_gnt   = host_gnt_s;
  assign core_stall = core_own_s & host_gnt_s;
  // Masking with rst drops a read whose data would surface during reset.
  assign host_rvalid = rvalid_q & ~rst;
  // BRAM output is already registered; pass it through only on the pulse.
  assign host_rdata  = host_rvalid ? ram_dout : {DATA_W{1'b0}};
  assign core_rst_n  = core_rst_n_q & ~rst;

endmodule

// File: tb/tb_useq_mem_arb.sv
// Self-checking bench for useq_mem_arb: reset checks, a vector table for
// single-cycle arbitration, directed multi-cycle sequences, then random
// traffic compared against a behavioural model of the sharing rules.
module tb_useq_mem_arb;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int SMAX   = 15;

  logic        clk = 1'b0;
  logic        rst, core_req, core_wren, host_halt, host_req, host_we, bram_clr;
  logic [11:0] core_addr, host_addr, ram_addr;
  logic [7:0]  core_wdata, host_wdata, ram_din, ram_dout, host_rdata;
  logic        core_stall, core_rst_n, host_gnt, host_rvalid, ram_wren;

  logic [7:0]  bram [0:4095];

  int checks = 0;
  int errors = 0;

  // Behavioural model state (touched only by the main initial block).
  logic [7:0]  m_mem [0:4095];
  bit          m_hh1, m_hh2, m_rst1, m_rd;
  logic [7:0]  m_rd_data;
  int          m_waited;

  typedef struct packed {
    logic        creq, cwren;
    logic [11:0] caddr;
    logic [7:0]  cwd;
    logic        hreq, hwe;
    logic [11:0] haddr;
    logic [7:0]  hwd;
    logic        egnt, estall, ewren;
    logic [11:0] eaddr;
    logic [7:0]  edin;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  useq_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_wren(core_wren),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_rst_n(core_rst_n),
    .host_halt(host_halt), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Bench-side BRAM, read-first, one cycle of read latency.
  always @(posedge clk) begin
    if (bram_clr) begin
      for (int i = 0; i < 4096; i++) bram[i] <= 8'h00;
      ram_dout <= 8'h00;
    end else begin
      if (ram_wren) bram[ram_addr] <= ram_din;
      ram_dout <= bram[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_wren = 1'b0; core_addr = 12'h000; core_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 12'h000; host_wdata = 8'h00;
  endtask

  function automatic logic [11:0] pick_addr();
    return ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
  endfunction

  // Model: the core is privileged only when host_halt was low in each of the
  // last two non-reset cycles; a host waiting SMAX contended cycles wins.
  task automatic model_step();
    bit         priv, core_on, e_gnt, e_stall, e_wren, e_rv, e_crn;
    logic [11:0] e_addr;
    logic [7:0]  e_din, e_rd;
    priv    = !m_hh1 && !m_hh2;
    core_on = !rst && priv && core_req;
    e_gnt   = !rst && host_req && (!priv || !core_req || (m_waited >= SMAX));
    e_stall = core_on && e_gnt;
    e_addr  = e_gnt ? host_addr : core_addr;
    e_wren  = e_gnt ? host_we : (core_on && core_wren);
    e_din   = e_gnt ? host_wdata : core_wdata;
    e_rv    = !rst && m_rd;
    e_rd    = e_rv ? m_rd_data : 8'h00;
    e_crn   = !rst && !m_rst1 && priv;
    chk("rnd_gnt", 32'(host_gnt), 32'(e_gnt));
    chk("rnd_stall", 32'(core_stall), 32'(e_stall));
    chk("rnd_wren", 32'(ram_wren), 32'(e_wren));
    chk("rnd_rvalid", 32'(host_rvalid), 32'(e_rv));
    chk("rnd_rdata", 32'(host_rdata), 32'(e_rd));
    chk("rnd_core_rst_n", 32'(core_rst_n), 32'(e_crn));
    if (e_gnt || core_on) chk("rnd_addr", 32'(ram_addr), 32'(e_addr));
    if (e_wren) chk("rnd_din", 32'(ram_din), 32'(e_din));
    if (e_gnt && !host_we) m_rd_data = m_mem[host_addr];
    if (e_wren) m_mem[e_addr] = e_din;
    m_rd = e_gnt && !host_we;
    if (rst || !priv || !host_req || e_gnt) m_waited = 0;
    else m_waited = (m_waited + 1 > SMAX) ? SMAX : m_waited + 1;
    if (rst) begin
      m_hh1 = 1'b0;
      m_hh2 = 1'b0;
    end else begin
      m_hh2 = m_hh1;
      m_hh1 = host_halt;
    end
    m_rst1 = rst;
  endtask

  initial begin
    int first_g, second_g, bad, ok;
    logic gs, ss;

    //            creq cwr caddr   cwd    hreq hwe haddr   hwd    gnt stl wr  eaddr   edin
    tbl[0] = '{1'b0,1'b1,12'h123,8'h44, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,1'b0,12'h123,8'h44};
    tbl[1] = '{1'b1,1'b1,12'h030,8'h66, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,1'b1,12'h030,8'h66};
    tbl[2] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b1,12'h040,8'h77, 1'b1,1'b0,1'b1,12'h040,8'h77};
    tbl[3] = '{1'b1,1'b0,12'h050,8'h99, 1'b1,1'b1,12'h060,8'h88, 1'b0,1'b0,1'b0,12'h050,8'h99};
    tbl[4] = '{1'b0,1'b1,12'h070,8'hAA, 1'b1,1'b0,12'h080,8'hBB, 1'b1,1'b0,1'b0,12'h080,8'hBB};
    tbl[5] = '{1'b1,1'b1,12'h090,8'hCC, 1'b1,1'b0,12'h0A0,8'hDD, 1'b0,1'b0,1'b1,12'h090,8'hCC};

    // Reset with requests active: everything must stay quiet.
    idle_inputs();
    host_halt = 1'b0; rst = 1'b1; bram_clr = 1'b1;
    host_req = 1'b1; core_req = 1'b1; core_wren = 1'b1;
    core_addr = 12'h001; host_addr = 12'h002;
    cyc();
    smp();
    chk("rst_gnt", 32'(host_gnt), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    cyc(); rst = 1'b0; bram_clr = 1'b0; idle_inputs();
    smp(); chk("crn_first_cycle", 32'(core_rst_n), 32'd0);
    cyc();
    smp(); chk("crn_rise", 32'(core_rst_n), 32'd1);

    // Single-cycle arbitration table, idle cycle between vectors.
    for (int i = 0; i < 6; i++) begin
      cyc();
      core_req = tbl[i].creq; core_wren = tbl[i].cwren;
      core_addr = tbl[i].caddr; core_wdata = tbl[i].cwd;
      host_req = tbl[i].hreq; host_we = tbl[i].hwe;
      host_addr = tbl[i].haddr; host_wdata = tbl[i].hwd;
      smp();
      chk($sformatf("vec%0d_gnt", i), 32'(host_gnt), 32'(tbl[i].egnt));
      chk($sformatf("vec%0d_stall", i), 32'(core_stall), 32'(tbl[i].estall));
      chk($sformatf("vec%0d_wren", i), 32'(ram_wren), 32'(tbl[i].ewren));
      chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(tbl[i].eaddr));
      chk($sformatf("vec%0d_din", i), 32'(ram_din), 32'(tbl[i].edin));
      cyc(); idle_inputs();
    end

    // Idle core: write 0x5A to 0x010, then read it back.
    cyc(); host_req = 1'b1; host_we = 1'b1; host_addr = 12'h010; host_wdata = 8'h5A;
    smp(); chk("idle_wr_gnt", 32'(host_gnt), 32'd1);
    cyc(); host_we = 1'b0;
    smp(); chk("idle_rd_gnt", 32'(host_gnt), 32'd1);
    chk("idle_wr_no_rvalid", 32'(host_rvalid), 32'd0);
    cyc(); host_req = 1'b0;
    smp(); chk("idle_rvalid", 32'(host_rvalid), 32'd1);
    chk("idle_rdata", 32'(host_rdata), 32'h5A);
    cyc();
    smp(); chk("idle_rvalid_pulse", 32'(host_rvalid), 32'd0);

    // Starvation: core always requesting, host always requesting.
    cyc(); core_req = 1'b1; core_addr = 12'h100; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h200;
    first_g = -1; second_g = -1; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      smp();
      if (host_gnt === 1'b1) begin
        if (first_g < 0) first_g = k;
        else if (second_g < 0) second_g = k;
      end
      if (core_stall !== host_gnt) bad++;
      cyc();
    end
    idle_inputs();
    chk("starve_first_grant", 32'(first_g), 32'd16);
    chk("starve_second_grant", 32'(second_g), 32'd32);
    chk("starve_stall_match", 32'(bad), 32'd0);

    // Contended write: host forced in at the limit, core write follows.
    cyc();
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h020; host_wdata = 8'h22;
    core_req = 1'b1; core_wren = 1'b0; core_addr = 12'h300;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      smp();
      if (host_gnt !== 1'b0) bad++;
      cyc();
    end
    chk("cw_wait_no_gnt", 32'(bad), 32'd0);
    core_wren = 1'b1; core_addr = 12'h020; core_wdata = 8'h11;
    smp();
    chk("cw_host_gnt", 32'(host_gnt), 32'd1);
    chk("cw_host_stall", 32'(core_stall), 32'd1);
    chk("cw_host_wren", 32'(ram_wren), 32'd1);
    chk("cw_host_din", 32'(ram_din), 32'h22);
    cyc(); host_req = 1'b0;
    smp();
    chk("cw_core_stall", 32'(core_stall), 32'd0);
    chk("cw_core_wren", 32'(ram_wren), 32'd1);
    chk("cw_core_addr", 32'(ram_addr), 32'h020);
    chk("cw_core_din", 32'(ram_din), 32'h11);
    cyc(); core_req = 1'b0; core_wren = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h020;
    smp(); chk("cw_rd_gnt", 32'(host_gnt), 32'd1);
    cyc(); host_req = 1'b0;
    smp();
    chk("cw_rvalid", 32'(host_rvalid), 32'd1);
    chk("cw_rdata", 32'(host_rdata), 32'h11);

    // Halt load: 256 back-to-back host writes with the core held off.
    cyc(); idle_inputs(); host_halt = 1'b1;
    smp(); chk("hl_entry_crn", 32'(core_rst_n), 32'd1);
    cyc(); core_req = 1'b1; core_wren = 1'b1; core_addr = 12'h007; core_wdata = 8'hEE;
    ok = 0;
    for (int i = 0; i < 256; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'(i); host_wdata = 8'(i) ^ 8'hA5;
      smp();
      if (host_gnt === 1'b1 && core_stall === 1'b0 && core_rst_n === 1'b0 &&
          ram_wren === 1'b1 && ram_addr === 12'(i) && ram_din === (8'(i) ^ 8'hA5)) ok++;
      cyc();
    end
    chk("hl_grants", 32'(ok), 32'd256);
    host_halt = 1'b0; idle_inputs();
    smp(); chk("hl_fall_crn", 32'(core_rst_n), 32'd0);
    cyc(); host_req = 1'b1; host_we = 1'b0; host_addr = 12'h005;
    smp();
    chk("hl_hrel_gnt", 32'(host_gnt), 32'd1);
    chk("hl_hrel_crn", 32'(core_rst_n), 32'd0);
    cyc(); host_req = 1'b0;
    smp();
    chk("hl_core_crn", 32'(core_rst_n), 32'd1);
    chk("hl_rvalid", 32'(host_rvalid), 32'd1);
    chk("hl_rdata", 32'(host_rdata), 32'hA0);
    cyc(); host_req = 1'b1; host_we = 1'b0; host_addr = 12'h007;
    cyc(); host_req = 1'b0;
    smp(); chk("hl_core_write_ignored", 32'(host_rdata), 32'hA2);

    // host_halt re-asserted during the release cycle returns to HALT.
    cyc(); host_halt = 1'b1;
    cyc(); host_halt = 1'b0;
    cyc(); host_halt = 1'b1;
    smp(); chk("rh_hrel_crn", 32'(core_rst_n), 32'd0);
    cyc(); core_req = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h000;
    smp();
    chk("rh_back_crn", 32'(core_rst_n), 32'd0);
    chk("rh_halt_gnt", 32'(host_gnt), 32'd1);
    chk("rh_halt_stall", 32'(core_stall), 32'd0);

    // Reset arriving while a halted-mode read is outstanding.
    cyc(); core_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010;
    smp(); chk("rm_read_gnt", 32'(host_gnt), 32'd1);
    cyc(); rst = 1'b1; host_req = 1'b0;
    smp(); chk("rm_rvalid_in_rst", 32'(host_rvalid), 32'd0);
    cyc(); rst = 1'b0; host_halt = 1'b0;
    smp();
    chk("rm_rvalid_after", 32'(host_rvalid), 32'd0);
    chk("rm_crn_low", 32'(core_rst_n), 32'd0);
    cyc(); core_req = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010;
    smp();
    chk("rm_crn_high", 32'(core_rst_n), 32'd1);
    chk("rm_core_state_gnt", 32'(host_gnt), 32'd0);
    cyc(); idle_inputs();

    // Boundary address 0xFFF.
    cyc(); host_req = 1'b1; host_we = 1'b1; host_addr = 12'hFFF; host_wdata = 8'hC3;
    smp(); chk("bd_wr_gnt", 32'(host_gnt), 32'd1);
    cyc(); host_we = 1'b0;
    smp(); chk("bd_ram_addr", 32'(ram_addr), 32'hFFF);
    cyc(); host_req = 1'b0;
    smp();
    chk("bd_rvalid", 32'(host_rvalid), 32'd1);
    chk("bd_rdata", 32'(host_rdata), 32'hC3);

    // Random traffic against the model, starting from a clean reset.
    cyc(); idle_inputs(); host_halt = 1'b0; rst = 1'b1; bram_clr = 1'b1;
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;
    m_hh1 = 1'b0; m_hh2 = 1'b0; m_rst1 = 1'b1; m_rd = 1'b0; m_rd_data = 8'h00; m_waited = 0;
    smp(); model_step();
    gs = 1'b0; ss = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      bram_clr = 1'b0;
      rst = ($urandom_range(0, 99) < 2);
      if (!(host_req && !gs)) begin
        host_req   = ($urandom_range(0, 2) != 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = pick_addr();
        host_wdata = 8'($urandom);
      end
      if (!ss) begin
        if ($urandom_range(0, 7) == 0) core_req = ~core_req;
        core_wren  = 1'($urandom_range(0, 1));
        core_addr  = pick_addr();
        core_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 23) == 0) host_halt = ~host_halt;
      smp();
      model_step();
      gs = host_gnt;
      ss = core_stall;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
